// File: rtl/ram_arb_pkg.sv
// Shared types and widths for the result-RAM controller.
// Holds the controller state encoding and the bus widths used by ram_arb
// and its picker.
package ram_arb_pkg;

  localparam int unsigned MU_W   = 18;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned RAM_W  = 32;
  localparam int unsigned BURST  = 4;
  localparam int unsigned BEAT_W = $clog2(BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_e;

endpackage

// File: rtl/ram_arb_pick.sv
// Two-requester alternating picker.
// Ports:
//   wb_elig, rd_elig : requesters eligible this cycle
//   last_wb          : previous grant went to writeback
//   gnt_wb, gnt_rd   : one-hot (or zero) grant
module ram_arb_pick (
  input  logic wb_elig,
  input  logic rd_elig,
  input  logic last_wb,
  output logic gnt_wb,
  output logic gnt_rd
);

  // On contention the requester not served last time wins.
  always_comb begin
    gnt_wb = 1'b0;
    gnt_rd = 1'b0;
    if (wb_elig && rd_elig) begin
      gnt_rd = last_wb;
      gnt_wb = !last_wb;
    end else begin
      gnt_wb = wb_elig;
      gnt_rd = rd_elig;
    end
  end

endmodule

// File: rtl/ram_arb.sv
// Single-port result-RAM controller: captures four MU results on wb_req and
// writes them as a 4-beat burst to consecutive addresses, interleaving
// single-word host reads with fair alternation.
// Optional feature macro: RAM_ARB_WRAP_EN (wrap the writeback pointer at the
// region end instead of raising full).
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   clr                 : pointer/full clear, honoured only in IDLE
//   wb_req, MU1..MU4    : writeback request and its four results
//   wb_ack              : grant pulse, results captured at this edge
//   rd_req, rd_addr     : host read request and word address
//   rd_ack              : grant pulse, rd_addr captured at this edge
//   rd_valid, rd_data   : read data strobe and data (held between strobes)
//   ram_en, ram_we      : RAM access enable / write select
//   address, dataRAM    : RAM word address and write data
//   ram_q               : RAM read data, one cycle after the read cycle
//   full                : writeback region exhausted
module ram_arb
  import ram_arb_pkg::*;
#(
  parameter logic [ADDR_W-1:0] WB_BASE  = 8'h00,
  parameter int unsigned       WB_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wb_req,
  input  logic [MU_W-1:0]   MU1,
  input  logic [MU_W-1:0]   MU2,
  input  logic [MU_W-1:0]   MU3,
  input  logic [MU_W-1:0]   MU4,
  output logic              wb_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [MU_W-1:0]   rd_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] address,
  output logic [RAM_W-1:0]  dataRAM,
  input  logic [RAM_W-1:0]  ram_q,
  output logic              full
);

  localparam logic [ADDR_W-1:0] WB_END = ADDR_W'(32'(WB_BASE) + WB_DEPTH - 32'd1);

  state_e              state, state_nx;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [BEAT_W-1:0]   beat;
  logic                last_wb;
  logic [MU_W-1:0]     wb_buf [BURST];
  logic [ADDR_W-1:0]   rd_lat;
  logic [MU_W-1:0]     rd_hold;
  logic                clr_idle, wb_elig, rd_elig, gnt_wb, gnt_rd, at_end;
  logic                unused;

  assign unused   = &{1'b0, ram_q[RAM_W-1:MU_W]};
  assign clr_idle = (state == IDLE) && clr;
  assign wb_elig  = (state == IDLE) && !clr && wb_req && !full;
  assign rd_elig  = (state == IDLE) && !clr && rd_req;
  assign at_end   = (state == WR) && (wr_ptr == WB_END);

  ram_arb_pick u_pick (
    .wb_elig (wb_elig),
    .rd_elig (rd_elig),
    .last_wb (last_wb),
    .gnt_wb  (gnt_wb),
    .gnt_rd  (gnt_rd)
  );

  // State register; reset drops the RAM port at once since outputs decode state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state and RAM-port decode.
  always_comb begin
    state_nx = state;
    wb_ack   = 1'b0;
    rd_ack   = 1'b0;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    address  = '0;
    dataRAM  = '0;
    case (state)
      IDLE: begin
        if (gnt_wb) begin
          wb_ack   = 1'b1;
          state_nx = WR;
        end else if (gnt_rd) begin
          rd_ack   = 1'b1;
          state_nx = RD;
        end
      end
      WR: begin
        ram_en  = 1'b1;
        ram_we  = 1'b1;
        address = wr_ptr;
        dataRAM = RAM_W'(wb_buf[beat]);
        if (beat == BEAT_W'(BURST - 1)) state_nx = IDLE;
      end
      RD: begin
        ram_en   = 1'b1;
        address  = rd_lat;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture buffers, pointers and arbitration history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= WB_BASE;
      beat     <= '0;
      last_wb  <= 1'b0;
      wb_buf   <= '{default: '0};
      rd_lat   <= '0;
      rd_valid <= 1'b0;
      rd_hold  <= '0;
    end else begin
      rd_valid <= (state == RD);
      if (rd_valid) rd_hold <= ram_q[MU_W-1:0];
      if (clr_idle) begin
        wr_ptr  <= WB_BASE;
        last_wb <= 1'b0;
      end
      if (gnt_wb) begin
        wb_buf[0] <= MU1;
        wb_buf[1] <= MU2;
        wb_buf[2] <= MU3;
        wb_buf[3] <= MU4;
        beat      <= '0;
        last_wb   <= 1'b1;
      end
      if (gnt_rd) begin
        rd_lat  <= rd_addr;
        last_wb <= 1'b0;
      end
      if (state == WR) begin
        beat <= beat + BEAT_W'(1);
        if (at_end) begin
`ifdef RAM_ARB_WRAP_EN
          wr_ptr <= WB_BASE;
`else
          wr_ptr <= wr_ptr;
`endif
        end else begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
        end
      end
    end
  end

  // Read data is live in the strobe cycle, otherwise the last captured word.
  assign rd_data = rd_valid ? ram_q[MU_W-1:0] : rd_hold;

`ifdef RAM_ARB_WRAP_EN
  assign full = 1'b0;
`else
  // Region-exhausted flag; only clr or reset bring it back down.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          full <= 1'b0;
    else if (clr_idle) full <= 1'b0;
    else if (at_end)   full <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ram_arb.sv
// Scoreboard bench for ram_arb: expected writes/reads are queued at grant
// time and compared when the RAM port or read strobe shows them.
module tb_ram_arb;
  import ram_arb_pkg::*;

`ifdef RAM_ARB_WRAP_EN
  localparam logic [7:0] BASE = 8'h10;
`else
  localparam logic [7:0] BASE = 8'h00;
`endif
  localparam int unsigned DEPTH = 8;
  localparam logic [7:0]  LAST  = 8'(32'(BASE) + DEPTH - 32'd1);

  typedef struct packed {
    logic [7:0]  addr;
    logic [17:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst, clr, wb_req, rd_req;
  logic [17:0] MU1, MU2, MU3, MU4;
  logic        wb_ack, rd_ack, rd_valid, ram_en, ram_we, full;
  logic [7:0]  rd_addr, address;
  logic [17:0] rd_data;
  logic [31:0] dataRAM;
  logic [31:0] ram_q = '0;

  int n_checks = 0;
  int n_errors = 0;

  wr_t         exp_wr[$];
  logic [17:0] exp_rd[$];
  logic        grant_log[$];
  logic [7:0]  m_ptr;
  bit          m_full;

  ram_arb #(.WB_BASE(BASE), .WB_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wb_req(wb_req),
    .MU1(MU1), .MU2(MU2), .MU3(MU3), .MU4(MU4), .wb_ack(wb_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data), .ram_en(ram_en), .ram_we(ram_we),
    .address(address), .dataRAM(dataRAM), .ram_q(ram_q), .full(full)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_pat(input logic [7:0] a);
    return {16'(a), 16'(a) + 16'd1};
  endfunction

  // Read-only RAM model: data appears the cycle after the read cycle.
  always @(posedge clk) if (ram_en && !ram_we) ram_q <= ram_pat(address);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_burst(input logic [17:0] a, b, c, d);
    logic [17:0] m [4];
    m = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      exp_wr.push_back({m_ptr, m[i]});
      if (m_ptr == LAST) begin
`ifdef RAM_ARB_WRAP_EN
        m_ptr = BASE;
`else
        m_full = 1'b1;
`endif
      end else begin
        m_ptr = m_ptr + 8'd1;
      end
    end
  endtask

  task automatic wb_txn(input logic [17:0] a, b, c, d, input int budget,
                        output bit acked, output int waited);
    MU1 = a; MU2 = b; MU3 = c; MU4 = d;
    wb_req = 1'b1;
    acked = 1'b0;
    waited = 0;
    while (!acked && waited < budget) begin
      @(negedge clk);
      if (wb_ack) begin
        acked = 1'b1;
        push_burst(a, b, c, d);
      end else begin
        waited++;
      end
    end
    @(posedge clk) #1 wb_req = 1'b0;
  endtask

  task automatic rd_txn(input logic [7:0] a, input int budget,
                        output bit acked, output int waited);
    logic [31:0] w;
    rd_addr = a;
    rd_req = 1'b1;
    acked = 1'b0;
    waited = 0;
    while (!acked && waited < budget) begin
      @(negedge clk);
      if (rd_ack) begin
        acked = 1'b1;
        w = ram_pat(a);
        exp_rd.push_back(w[17:0]);
      end else begin
        waited++;
      end
    end
    @(posedge clk) #1 rd_req = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard side: log grants, compare RAM writes and read strobes.
  always @(negedge clk) begin : mon
    wr_t         e;
    logic [17:0] r;
    if (rst) begin
      if (wb_ack) grant_log.push_back(1'b1);
      if (rd_ack) grant_log.push_back(1'b0);
      if (ram_en && ram_we) begin
        if (exp_wr.size() == 0) begin
          check("spurious_write", 32'(ram_we), 32'd0);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", 32'(address), 32'(e.addr));
          check("wr_data", dataRAM, {14'b0, e.data});
        end
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0) begin
          check("spurious_rd_valid", 32'(rd_valid), 32'd0);
        end else begin
          r = exp_rd.pop_front();
          check("rd_data", 32'(rd_data), 32'(r));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit acked;
    int waited;
    bit exp_ack;
    rst = 1'b0; clr = 1'b0; wb_req = 1'b0; rd_req = 1'b0;
    MU1 = '0; MU2 = '0; MU3 = '0; MU4 = '0; rd_addr = '0;
    m_ptr = BASE; m_full = 1'b0;

    // Reset state
    tick(2);
    check("rst_ram_en",   32'(ram_en),   32'd0);
    check("rst_ram_we",   32'(ram_we),   32'd0);
    check("rst_address",  32'(address),  32'd0);
    check("rst_dataRAM",  dataRAM,       32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data",  32'(rd_data),  32'd0);
    check("rst_full",     32'(full),     32'd0);
    rst = 1'b1;
    tick(1);

    // Single burst 1,2,3,4
    wb_txn(18'd1, 18'd2, 18'd3, 18'd4, 10, acked, waited);
    check("wb1_ack", 32'(acked), 32'd1);
    check("wb1_ack_latency", 32'(waited), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("wb1_beat_en_we", 32'({ram_en, ram_we}), 32'b11);
      tick(1);
    end
    check("wb1_idle_after", 32'(ram_en), 32'd0);

    // Single read at 0x02
    rd_txn(8'h02, 10, acked, waited);
    check("rd1_ack", 32'(acked), 32'd1);
    check("rd1_read_cycle", 32'({ram_en, ram_we, address}), 32'({1'b1, 1'b0, 8'h02}));
    tick(1);
    check("rd1_valid", 32'(rd_valid), 32'd1);
    tick(3);
    check("rd1_valid_drop", 32'(rd_valid), 32'd0);
    check("rd1_hold", 32'(rd_data), 32'h20003);

    // Clear pointer, then contending requesters
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    m_ptr = BASE; m_full = 1'b0;
    check("clr_full", 32'(full), 32'd0);
    grant_log.delete();
    fork
      begin
        bit a1; int w1;
        for (int i = 0; i < 2; i++) begin
          wb_txn(18'h100 + 18'(i * 4), 18'h101 + 18'(i * 4),
                 18'h102 + 18'(i * 4), 18'h103 + 18'(i * 4), 20, a1, w1);
          check("alt_wb_ack", 32'(a1), 32'd1);
        end
      end
      begin
        bit a2; int w2;
        for (int i = 0; i < 2; i++) begin
          rd_txn(8'h40 + 8'(i), 20, a2, w2);
          check("alt_rd_ack", 32'(a2), 32'd1);
        end
      end
    join
    tick(3);
    check("alt_grant_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < grant_log.size() && i < 4; i++)
      check("alt_grant_order", 32'(grant_log[i]), 32'((i % 2) == 0));
    check("full_after_region", 32'(full), 32'(m_full));

    // Third burst: refused when full, wraps otherwise
    exp_ack = !m_full;
    wb_txn(18'h3AAAA, 18'h3BBBB, 18'h3CCCC, 18'h3DDDD, 10, acked, waited);
    check("wb3_ack", 32'(acked), 32'(exp_ack));
    rd_txn(8'h05, 12, acked, waited);
    check("rd_while_full_ack", 32'(acked), 32'd1);
    tick(4);
    check("full_hold", 32'(full), 32'(m_full));

    // clr in IDLE restarts the region
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    m_ptr = BASE; m_full = 1'b0;
    check("clr2_full", 32'(full), 32'd0);
    wb_txn(18'h11, 18'h22, 18'h33, 18'h44, 10, acked, waited);
    check("wb_after_clr_ack", 32'(acked), 32'd1);
    tick(5);

    // Reset at beat 2 of a burst
    wb_txn(18'h55, 18'h66, 18'h77, 18'h88, 10, acked, waited);
    check("wb_rst_ack", 32'(acked), 32'd1);
    tick(1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_ram_en",  32'(ram_en),  32'd0);
    check("midrst_ram_we",  32'(ram_we),  32'd0);
    check("midrst_address", 32'(address), 32'd0);
    check("midrst_dataRAM", dataRAM,      32'd0);
    exp_wr.delete();
    m_ptr = BASE; m_full = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);

    // Post-reset burst starts at base; clr mid-burst is ignored
    wb_txn(18'h1, 18'h2, 18'h3, 18'h4, 10, acked, waited);
    check("wb_post_rst_ack", 32'(acked), 32'd1);
    tick(1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(4);

    check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
